// File: rtl/pe_result_collector_pkg.sv
// Shared geometry, lane mapping and drain-state encodings for the PE cube result path.
package pe_result_collector_pkg;

    localparam int unsigned LANE_W     = 8;
    localparam int unsigned CUBE_NUM   = 3;
    localparam int unsigned BLOCK_NUM  = 3;
    localparam int unsigned ARRAY_NUM  = 3;
    localparam int unsigned LANES      = ARRAY_NUM * BLOCK_NUM * CUBE_NUM;
    localparam int unsigned BEAT_LANES = ARRAY_NUM * BLOCK_NUM;
    localparam int unsigned FRAME_W    = LANE_W * LANES;
    localparam int unsigned BEAT_W     = LANE_W * BEAT_LANES;
    localparam int unsigned BEAT_IDX_W = (CUBE_NUM > 1) ? $clog2(CUBE_NUM) : 1;
    localparam int unsigned FCNT_W     = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } drain_state_e;

    // Lane k occupies bits [lane_lsb(k) +: LANE_W] of the result bus.
    function automatic int unsigned lane_lsb(input int unsigned lane);
        return lane * LANE_W;
    endfunction

endpackage

// File: rtl/pe_result_serializer.sv
// Drain buffer for one captured frame, sent as one beat per cube on a valid/ready stream.
module pe_result_serializer
    import pe_result_collector_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    input  logic               ready,
    output logic [BEAT_W-1:0]  data,
    output logic               valid,
    output logic               last,
    output logic [FCNT_W-1:0]  frame_cnt,
    output logic               drain_free_c,
    output logic               send_next_c
);

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(CUBE_NUM - 1);

    drain_state_e            state_q, state_d;
    logic [BEAT_IDX_W-1:0]   beat_q, beat_d;
    logic [FRAME_W-1:0]      buf_q, buf_d;
    logic [BEAT_W-1:0]       data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic [FCNT_W-1:0]       cnt_q, cnt_d;

    logic                    hs_c;
    logic                    last_beat_c;
    logic [BEAT_IDX_W-1:0]   beat_nxt_c;

    assign hs_c        = valid_q && ready;
    assign last_beat_c = (beat_q == LAST_BEAT);
    assign beat_nxt_c  = beat_q + BEAT_IDX_W'(1);

    // Next state; a load on the final handshake restarts at beat 0 with no bubble.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        buf_d        = buf_q;
        data_d       = data_q;
        valid_d      = valid_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        drain_free_c = (state_q == ST_IDLE) || (last_beat_c && hs_c);

        if (state_q == ST_SEND && hs_c) begin
            if (!last_beat_c) begin
                beat_d = beat_nxt_c;
                data_d = buf_q[32'(beat_nxt_c) * BEAT_W +: BEAT_W];
                last_d = (beat_nxt_c == LAST_BEAT);
            end else begin
                cnt_d   = cnt_q + FCNT_W'(1);
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        end

        if (load && drain_free_c) begin
            state_d = ST_SEND;
            beat_d  = '0;
            buf_d   = frame;
            data_d  = frame[BEAT_W-1:0];
            last_d  = (LAST_BEAT == '0);
            valid_d = 1'b1;
        end

        send_next_c = (state_d == ST_SEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign last      = last_q;
    assign frame_cnt = cnt_q;

endmodule

// File: rtl/pe_result_collector.sv
// Captures staggered per-lane PE results into a frame buffer and hands full frames to the serializer.
module pe_result_collector
    import pe_result_collector_pkg::*;
(
    input  logic                iClk,
    input  logic                iRst,
    input  logic [FRAME_W-1:0]  iResult,
    input  logic [LANES-1:0]    iResultValid,
    output logic [BEAT_W-1:0]   oData,
    output logic                oValid,
    input  logic                iReady,
    output logic                oLast,
    output logic [FCNT_W-1:0]   oFrameCnt,
    output logic                oOverflow,
    output logic                oBusy
);

    logic [FRAME_W-1:0] cap_q, cap_d;
    logic [LANES-1:0]   cap_vld_q, cap_vld_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;

    logic               drain_free_c;
    logic               send_next_c;
    logic               xfer_c;

    assign xfer_c = (&cap_vld_q) && drain_free_c;

    // Strobes in the transfer cycle land after the clear, so they never count as overflow.
    always_comb begin
        cap_d      = cap_q;
        cap_vld_d  = xfer_c ? '0 : cap_vld_q;
        overflow_d = overflow_q;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (iResultValid[k]) begin
                if (cap_vld_d[k]) begin
                    overflow_d = 1'b1;
                end else begin
                    cap_d[lane_lsb(k) +: LANE_W] = iResult[lane_lsb(k) +: LANE_W];
                    cap_vld_d[k]                 = 1'b1;
                end
            end
        end
        busy_d = (|cap_vld_d) || send_next_c;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cap_q      <= '0;
            cap_vld_q  <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cap_q      <= cap_d;
            cap_vld_q  <= cap_vld_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    pe_result_serializer u_serializer (
        .clk          (iClk),
        .rst          (iRst),
        .load         (xfer_c),
        .frame        (cap_q),
        .ready        (iReady),
        .data         (oData),
        .valid        (oValid),
        .last         (oLast),
        .frame_cnt    (oFrameCnt),
        .drain_free_c (drain_free_c),
        .send_next_c  (send_next_c)
    );

    assign oOverflow = overflow_q;
    assign oBusy     = busy_q;

endmodule
